fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, fetch address after reset.
REQ-002 SHALL have parameter BUS_WIDTH, default 3, log2 of bytes per memory word (8-byte cells).
REQ-003 SHALL have clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have mem_addr, output, 64, byte address to RAM, always word-aligned (low BUS_WIDTH bits zero).
REQ-006 SHALL have mem_rw, output, 1, RAM write strobe, constant 0 (read-only master).
REQ-007 SHALL have mem_read, input, 64, combinational RAM read data for mem_addr.
REQ-008 SHALL have mem_exception, input, 1, RAM out-of-range flag for mem_addr.
REQ-009 SHALL have redirect_valid, input, 1, redirect request from execute stage.
REQ-010 SHALL have redirect_pc, input, 64, new fetch byte address.
REQ-011 SHALL have instr_valid, output, 1, instruction available to decoder.
REQ-012 SHALL have instr_ready, input, 1, decoder accepts instruction.
REQ-013 SHALL have instr, output, 32, RV instruction word.
REQ-014 SHALL have instr_pc, output, 64, byte address of instr.
REQ-015 SHALL have fault, output, 1, fetch halted on error; fault_cause, output, 2: 01 memory range, 10 misaligned redirect.

Function
REQ-016 SHALL implement states FETCH, ISSUE, FAULT.
REQ-017 FETCH: mem_addr = pc with low BUS_WIDTH bits cleared; at next edge capture mem_read into word buffer, go ISSUE; if mem_exception, go FAULT, fault_cause=01.
REQ-018 ISSUE: instr_valid=1; instr = buffer[31:0] when pc[2]=0, buffer[63:32] when pc[2]=1 (little-endian); instr_pc = pc.
REQ-019 Handshake: transfer only when instr_valid && instr_ready; instr, instr_pc stable while instr_valid && !instr_ready.
REQ-020 On transfer pc <= pc+4 (64-bit wrap at 2^64); pc[2]=0 stays ISSUE (high half, no memory access); pc[2]=1 goes FETCH.
REQ-021 Latency: one edge from FETCH to instr_valid; sequential throughput 2 instructions per 3 cycles with instr_ready held 1.
REQ-022 redirect_valid has priority over all transfers in any state: pc <= redirect_pc, buffer invalidated, go FETCH; an instruction offered same cycle is NOT transferred.
REQ-023 Redirect with redirect_pc[1:0]!=0: go FAULT, fault_cause=10, pc <= redirect_pc.
REQ-024 FAULT: instr_valid=0, fault=1, mem_addr holds; exit only by aligned redirect.
REQ-025 instr_valid SHALL never be 1 in FETCH or FAULT.

Reset
REQ-026 On rst: pc=RESET_PC, state FETCH, instr_valid=0, instr=0, instr_pc=0, fault=0, fault_cause=00, buffer=0, counters=0.
REQ-027 rst mid-ISSUE SHALL drop instr_valid immediately (asynchronous); in-flight instruction discarded.

Configuration
REQ-028 Macro FETCH_STATS_EN defined: ports fetch_cnt[31:0] (memory word captures) and stall_cnt[31:0] (cycles instr_valid && !instr_ready), both saturating at 32'hFFFFFFFF.
REQ-029 FETCH_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-030 Package fetch_pkg SHALL hold XLEN=64, INSTR_W=32, state enum, fault_cause encodings.
REQ-031 Counters SHALL live in sub-module fetch_stats, instantiated only under FETCH_STATS_EN.

Verification
REQ-032 Reset RESET_PC=0, RAM word0=64'h0fc1059700100513, instr_ready=1 -> instr 32'h00100513 @pc 0, then 32'h0fc10597 @pc 4, one cycle apart.
REQ-033 Continue -> FETCH cycle with instr_valid=0, then 32'h00d00613 @8, 32'h00d00613 @12, 32'h04000893 @16, 32'h00000073 @20.
REQ-034 instr_ready=0 for 5 cycles at pc 4 -> instr 32'h0fc10597 held, pc unchanged, stall_cnt=5 with FETCH_STATS_EN.
REQ-035 redirect_pc=64'h18 with instr_valid && instr_ready same cycle -> no transfer, next instruction 32'h05d00893 @pc 24.
REQ-036 redirect_pc=64'h2000 (beyond 4 KiB) -> fault=1, fault_cause=01, instr_valid=0 until redirect_pc=0 restores 32'h00100513.
REQ-037 redirect_pc=64'h6 -> fault_cause=10; rst asserted mid-ISSUE -> instr_valid=0 same cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FSM states and fault cause encodings for the fetch unit
package fetch_pkg;

   localparam int XLEN    = 64;
   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_ISSUE = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MEM      = 2'b01;
   localparam logic [1:0] FC_MISALIGN = 2'b10;

endpackage

// File: rtl/fetch_stats.sv
// rtl/fetch_stats.sv - saturating word-capture and decoder-stall counters
module fetch_stats (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_fetch_inc,
   input  logic        i_stall_inc,
   output logic [31:0] o_fetch_cnt,
   output logic [31:0] o_stall_cnt
);

   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (i_fetch_inc && (r_fetch_cnt != 32'hFFFF_FFFF))
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (i_stall_inc && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign o_fetch_cnt = r_fetch_cnt;
   assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV instruction fetch: one 64-bit word read feeds two 32-bit issues
// Optional counters enabled by defining FETCH_STATS_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          BUS_WIDTH = 3
) (
   input  logic               clk,
   input  logic               rst,
   output logic [XLEN-1:0]    mem_addr,
   output logic               mem_rw,
   input  logic [XLEN-1:0]    mem_read,
   input  logic               mem_exception,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [XLEN-1:0]    instr_pc,
   output logic               fault,
   output logic [1:0]         fault_cause
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   state_e          r_state;
   state_e          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] r_buf;
   logic [XLEN-1:0] w_buf_nxt;
   logic [1:0]      r_cause;
   logic [1:0]      w_cause_nxt;
   logic            w_issue;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_pc    <= RESET_PC;
         r_buf   <= '0;
         r_cause <= FC_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_buf   <= w_buf_nxt;
         r_cause <= w_cause_nxt;
      end
   end

   // A redirect overrides everything, including an instruction being accepted this cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_buf_nxt   = r_buf;
      w_cause_nxt = r_cause;
      if (redirect_valid) begin
         w_pc_nxt  = redirect_pc;
         w_buf_nxt = '0;
         if (redirect_pc[1:0] != 2'b00) begin
            w_state_nxt = ST_FAULT;
            w_cause_nxt = FC_MISALIGN;
         end else begin
            w_state_nxt = ST_FETCH;
            w_cause_nxt = FC_NONE;
         end
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (mem_exception) begin
                  w_state_nxt = ST_FAULT;
                  w_cause_nxt = FC_MEM;
               end else begin
                  w_buf_nxt   = mem_read;
                  w_state_nxt = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (instr_ready) begin
                  w_pc_nxt = r_pc + 64'd4;
                  // Leaving the high half means the buffered word is used up.
                  if (r_pc[2])
                     w_state_nxt = ST_FETCH;
               end
            end
            ST_FAULT: ;
            default:  w_state_nxt = ST_FETCH;
         endcase
      end
   end

   assign w_issue     = (r_state == ST_ISSUE);
   assign mem_addr    = r_pc & ~((64'd1 << BUS_WIDTH) - 64'd1);
   assign mem_rw      = 1'b0;
   assign instr_valid = w_issue;
   assign instr       = w_issue ? (r_pc[2] ? r_buf[63:32] : r_buf[31:0]) : '0;
   assign instr_pc    = w_issue ? r_pc : '0;
   assign fault       = (r_state == ST_FAULT);
   assign fault_cause = r_cause;

`ifdef FETCH_STATS_EN
   logic w_capture;
   logic w_stall;

   assign w_capture = (r_state == ST_FETCH) && !redirect_valid && !mem_exception;
   assign w_stall   = w_issue && !instr_ready;

   fetch_stats u_stats (
      .clk         (clk),
      .rst         (rst),
      .i_fetch_inc (w_capture),
      .i_stall_inc (w_stall),
      .o_fetch_cnt (fetch_cnt),
      .o_stall_cnt (stall_cnt)
   );
`else
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit against a 4 KiB RAM model
`timescale 1ns/1ps
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [63:0] mem_addr;
   logic        mem_rw;
   logic [63:0] mem_read;
   logic        mem_exception;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        fault;
   logic [1:0]  fault_cause;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   logic [63:0] ram [0:511];
   int          n_vec;
   int          n_err;

   fetch_unit #(
      .RESET_PC  (64'h0),
      .BUS_WIDTH (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_addr       (mem_addr),
      .mem_rw         (mem_rw),
      .mem_read       (mem_read),
      .mem_exception  (mem_exception),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .fault          (fault),
      .fault_cause    (fault_cause)
`ifdef FETCH_STATS_EN
      ,
      .fetch_cnt      (fetch_cnt),
      .stall_cnt      (stall_cnt)
`endif
   );

   assign mem_exception = (mem_addr >= 64'd4096);
   assign mem_read      = mem_exception ? 64'h0 : ram[mem_addr[11:3]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 512; i++) ram[i] = 64'h0;
      ram[0] = 64'h0fc1059700100513;
      ram[1] = 64'h00d0061300d00613;
      ram[2] = 64'h0000007304000893;
      ram[3] = 64'h0000001305d00893;

      rst            = 1'b1;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      #1;
      check("rst_valid", {63'h0, instr_valid}, 64'h0);
      check("rst_instr", {32'h0, instr}, 64'h0);
      check("rst_pc", instr_pc, 64'h0);
      check("rst_fault", {62'h0, fault_cause, fault} , 64'h0);
      check("rst_addr", mem_addr, 64'h0);
      check("mem_rw", {63'h0, mem_rw}, 64'h0);
      tick();
      tick();
      rst         = 1'b0;
      instr_ready = 1'b1;
      check("fetch0_valid", {63'h0, instr_valid}, 64'h0);

      tick();
      check("i0_valid", {63'h0, instr_valid}, 64'h1);
      check("i0_instr", {32'h0, instr}, 64'h00100513);
      check("i0_pc", instr_pc, 64'h0);
      tick();
      check("i1_instr", {32'h0, instr}, 64'h0fc10597);
      check("i1_pc", instr_pc, 64'h4);

      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_instr", {32'h0, instr}, 64'h0fc10597);
         check("stall_pc", instr_pc, 64'h4);
      end
`ifdef FETCH_STATS_EN
      check("stall_cnt", {32'h0, stall_cnt}, 64'd5);
      check("fetch_cnt", {32'h0, fetch_cnt}, 64'd1);
`endif
      instr_ready = 1'b1;

      tick();
      check("fetch8_valid", {63'h0, instr_valid}, 64'h0);
      check("fetch8_addr", mem_addr, 64'h8);
      tick();
      check("i8_instr", {32'h0, instr}, 64'h00d00613);
      check("i8_pc", instr_pc, 64'h8);
      tick();
      check("i12_instr", {32'h0, instr}, 64'h00d00613);
      check("i12_pc", instr_pc, 64'hc);
      tick();
      check("fetch16_valid", {63'h0, instr_valid}, 64'h0);
      tick();
      check("i16_instr", {32'h0, instr}, 64'h04000893);
      check("i16_pc", instr_pc, 64'h10);
      tick();
      check("i20_instr", {32'h0, instr}, 64'h00000073);
      check("i20_pc", instr_pc, 64'h14);

      redirect_valid = 1'b1;
      redirect_pc    = 64'h18;
      tick();
      redirect_valid = 1'b0;
      check("redir18_valid", {63'h0, instr_valid}, 64'h0);
      check("redir18_addr", mem_addr, 64'h18);
      tick();
      check("i24_instr", {32'h0, instr}, 64'h05d00893);
      check("i24_pc", instr_pc, 64'h18);

      // Redirect in the low half with ready=1: a transfer would stay in ISSUE at pc 28.
      redirect_valid = 1'b1;
      redirect_pc    = 64'h10;
      tick();
      redirect_valid = 1'b0;
      check("redir_prio_valid", {63'h0, instr_valid}, 64'h0);
      check("redir_prio_addr", mem_addr, 64'h10);
      tick();
      check("r16_instr", {32'h0, instr}, 64'h04000893);
      check("r16_pc", instr_pc, 64'h10);

      redirect_valid = 1'b1;
      redirect_pc    = 64'h2000;
      tick();
      redirect_valid = 1'b0;
      check("oor_fetch_valid", {63'h0, instr_valid}, 64'h0);
      check("oor_addr", mem_addr, 64'h2000);
      tick();
      check("oor_fault", {63'h0, fault}, 64'h1);
      check("oor_cause", {62'h0, fault_cause}, 64'h1);
      check("oor_valid", {63'h0, instr_valid}, 64'h0);
      tick();
      check("oor_hold_fault", {63'h0, fault}, 64'h1);
      check("oor_hold_addr", mem_addr, 64'h2000);
      check("oor_hold_valid", {63'h0, instr_valid}, 64'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      tick();
      redirect_valid = 1'b0;
      check("recover_fault", {63'h0, fault}, 64'h0);
      check("recover_cause", {62'h0, fault_cause}, 64'h0);
      tick();
      check("recover_instr", {32'h0, instr}, 64'h00100513);
      check("recover_pc", instr_pc, 64'h0);

      redirect_valid = 1'b1;
      redirect_pc    = 64'h6;
      tick();
      redirect_valid = 1'b0;
      check("mis_fault", {63'h0, fault}, 64'h1);
      check("mis_cause", {62'h0, fault_cause}, 64'h2);
      check("mis_valid", {63'h0, instr_valid}, 64'h0);
      tick();
      check("mis_hold", {63'h0, fault}, 64'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      tick();
      redirect_valid = 1'b0;
      tick();
      check("pre_rst_valid", {63'h0, instr_valid}, 64'h1);

      instr_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", {63'h0, instr_valid}, 64'h0);
      check("async_rst_instr", {32'h0, instr}, 64'h0);
      tick();
      rst         = 1'b0;
      instr_ready = 1'b1;
      check("post_rst_fetch", {63'h0, instr_valid}, 64'h0);
      tick();
      check("refetch_instr", {32'h0, instr}, 64'h00100513);
      check("refetch_pc", instr_pc, 64'h0);
`ifdef FETCH_STATS_EN
      check("rst_cnt_clear", {32'h0, stall_cnt}, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
